spwm_seq: RTL and testbench

Parametrised SPWM sequencer; replaces the fixed nine-state quarter-wave FSM. It walks a sine-table index up and down across the four quadrants of each output cycle and paces every sample from the carrier generator's `rdy` pulse. It adds four things the fixed FSM lacked: a runtime-programmable quarter length, a unipolar mode, a zero-crossing dead time, and a graceful stop at the cycle boundary. It sits between the PWM carrier/comparator block and the sine lookup ROM.

---
 rtl/spwm_pkg.sv | 21 ++
 rtl/spwm_dead_timer.sv | 38 +++
 rtl/spwm_seq.sv | 160 ++++++++++++++++
 tb/tb_spwm_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// spwm_pkg: definitions shared by the SPWM sequencer and its dead-time timer.
//   seqState_t : sequencer states (IDLE, RUN, DEAD)
//   QUAD_0..3  : quadrant encodings of the output waveform
//   DEF_AW     : default sine ROM index width
`timescale 1ns/1ps
package spwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } seqState_t;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam int DEF_AW = 8;

endpackage

// File: rtl/spwm_dead_timer.sv
// spwm_dead_timer: load/count/done down-counter for the zero-crossing dead time.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   load  : preload DEAD_CYC (takes priority over count)
//   count : decrement while nonzero
//   done  : high while the counter sits at 1, i.e. during the last dead clock
`timescale 1ns/1ps
module spwm_dead_timer #(
    parameter int DEAD_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);

    // A zero dead time would give a zero-width counter; keep one bit so the
    // module still elaborates (the sequencer never loads it in that case).
    localparam int CW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(DEAD_CYC);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Loaded on the half-ending edge, so the value 1 is seen on the
    // DEAD_CYC-th dead clock; the sequencer leaves DEAD on the following edge.
    assign done = (cnt == CW'(1));

endmodule

// File: rtl/spwm_seq.sv
// spwm_seq: SPWM sequencer walking the sine ROM index across four quadrants.
//   clk, rst          : clock, asynchronous active-low reset
//   en                : run request (stop only takes effect at a cycle boundary)
//   uni               : 1 = unipolar, 0 = bipolar (latched with qlen)
//   qlen              : samples per quarter Q (0 keeps the block idle)
//   rdy               : carrier generator finished the current sample
//   idx, quad, dir    : ROM address, quadrant, rising-magnitude flag
//   pwm_en            : carrier/comparator enable
//   pol_p, pol_n      : bridge polarity selects
//   sample_stb        : new idx valid (ROM read strobe)
//   cyc_done          : full output cycle finished
//   busy              : sequencer not idle
// Handshake: rdy is a single-clock pulse; every rdy seen in RUN advances
// exactly one sample, and the resulting idx is presented together with a
// one-clock sample_stb on the following clock. rdy is ignored outside RUN.
`timescale 1ns/1ps
module spwm_seq
    import spwm_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DEAD_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          uni,
    input  logic [AW-1:0] qlen,
    input  logic          rdy,
    output logic [AW-1:0] idx,
    output logic [1:0]    quad,
    output logic          dir,
    output logic          pwm_en,
    output logic          pol_p,
    output logic          pol_n,
    output logic          sample_stb,
    output logic          cyc_done,
    output logic          busy
);

    seqState_t     state, stateNext;
    logic [AW-1:0] qR, qNext;
    logic          uniR, uniNext;
    logic [AW-1:0] idxNext;
    logic [1:0]    quadNext;
    logic          stbNext, doneNext, boundary;
    logic          pwmEnNext, polPNext, polNNext, dirNext, busyNext;
    logic          timerLoad, timerDone;

    spwm_dead_timer #(.DEAD_CYC(DEAD_CYC)) deadTimer (
        .clk   (clk),
        .rst   (rst),
        .load  (timerLoad),
        .count (state == DEAD),
        .done  (timerDone)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            qR         <= '0;
            uniR       <= 1'b0;
            idx        <= '0;
            quad       <= QUAD_0;
            dir        <= 1'b0;
            pwm_en     <= 1'b0;
            pol_p      <= 1'b0;
            pol_n      <= 1'b0;
            sample_stb <= 1'b0;
            cyc_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            qR         <= qNext;
            uniR       <= uniNext;
            idx        <= idxNext;
            quad       <= quadNext;
            dir        <= dirNext;
            pwm_en     <= pwmEnNext;
            pol_p      <= polPNext;
            pol_n      <= polNNext;
            sample_stb <= stbNext;
            cyc_done   <= doneNext;
            busy       <= busyNext;
        end
    end

    always_comb begin
        stateNext = state;
        qNext     = qR;
        uniNext   = uniR;
        idxNext   = idx;
        quadNext  = quad;
        stbNext   = 1'b0;
        doneNext  = 1'b0;
        boundary  = 1'b0;
        timerLoad = 1'b0;

        case (state)
            IDLE: begin
                if (en && (qlen != '0)) begin
                    stateNext = RUN;
                    qNext     = qlen;
                    uniNext   = uni;
                    idxNext   = '0;
                    quadNext  = QUAD_0;
                    stbNext   = 1'b1;
                end
            end
            RUN: begin
                if (rdy) begin
                    stbNext = 1'b1;
                    if (!quad[0]) begin
                        // Rising quarter: the peak Q belongs to the odd quadrant.
                        if (idx == qR - AW'(1)) begin
                            idxNext  = qR;
                            quadNext = quad + 2'd1;
                        end else begin
                            idxNext = idx + AW'(1);
                        end
                    end else if (idx != AW'(1)) begin
                        idxNext = idx - AW'(1);
                    end else begin
                        // Half ends; zero belongs to the next even quadrant.
                        idxNext  = '0;
                        quadNext = uniR ? QUAD_0 : quad + 2'd1;
                        boundary = uniR || (quad == QUAD_3);
                        if (boundary) begin
                            doneNext = 1'b1;
                            qNext    = qlen;
                            uniNext  = uni;
                        end
                        if (boundary && (!en || (qlen == '0))) begin
                            stateNext = IDLE;
                            stbNext   = 1'b0;
                            quadNext  = QUAD_0;
                        end else if (!uniR && (DEAD_CYC > 0)) begin
                            stateNext = DEAD;
                            stbNext   = 1'b0;
                            timerLoad = 1'b1;
                        end
                    end
                end
            end
            DEAD: begin
                if (timerDone) begin
                    stateNext = RUN;
                    stbNext   = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        pwmEnNext = (stateNext == RUN);
        polPNext  = pwmEnNext && ((quadNext < QUAD_2) || uniNext);
        polNNext  = pwmEnNext && !polPNext;
        busyNext  = (stateNext != IDLE);
        dirNext   = busyNext && !quadNext[0];
    end

endmodule

// File: tb/tb_spwm_seq.sv
`timescale 1ns/1ps
module tb_spwm_seq;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic uni = 1'b0;
  logic rdy = 1'b0;
  logic [AW-1:0] qlen = '0;

  logic [AW-1:0] idx, idx0;
  logic [1:0] quad, quad0;
  logic dir, pwm_en, pol_p, pol_n, sample_stb, cyc_done, busy;
  logic dir0, pwm_en0, pol_p0, pol_n0, sample_stb0, cyc_done0, busy0;

  // obs packs {idx, quad, busy, pwm_en, pol_p, pol_n, sample_stb, cyc_done, dir}
  logic [16:0] obs, obs0;
  assign obs  = {idx, quad, busy, pwm_en, pol_p, pol_n, sample_stb, cyc_done, dir};
  assign obs0 = {idx0, quad0, busy0, pwm_en0, pol_p0, pol_n0, sample_stb0, cyc_done0, dir0};

  int n_tests = 0;
  int n_fail = 0;

  // bipolar Q=3 sample table, position = rdy count mod 12
  int bip_i[12] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
  int bip_q[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int uni_i[4] = '{0, 1, 2, 1};
  int uni_q[4] = '{0, 0, 1, 1};
  int q5_i[6] = '{1, 2, 3, 4, 5, 4};
  int q5_q[6] = '{0, 0, 0, 0, 1, 1};

  spwm_seq #(.AW(AW), .DEAD_CYC(4)) dut (
    .clk(clk), .rst(rst), .en(en), .uni(uni), .qlen(qlen), .rdy(rdy),
    .idx(idx), .quad(quad), .dir(dir), .pwm_en(pwm_en), .pol_p(pol_p),
    .pol_n(pol_n), .sample_stb(sample_stb), .cyc_done(cyc_done), .busy(busy)
  );

  spwm_seq #(.AW(AW), .DEAD_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .uni(uni), .qlen(qlen), .rdy(rdy),
    .idx(idx0), .quad(quad0), .dir(dir0), .pwm_en(pwm_en0), .pol_p(pol_p0),
    .pol_n(pol_n0), .sample_stb(sample_stb0), .cyc_done(cyc_done0), .busy(busy0)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // expected-value model
  function automatic logic [16:0] mk(input int i, input int q, input logic b, input logic pw,
                                     input logic pp, input logic pn, input logic st,
                                     input logic cd, input logic dr);
    return {AW'(i), 2'(q), b, pw, pp, pn, st, cd, dr};
  endfunction

  function automatic logic [16:0] run_exp(input int i, input int q, input logic um,
                                          input logic st, input logic cd);
    logic pos;
    pos = (q < 2) || um;
    return mk(i, q, 1'b1, 1'b1, pos, !pos, st, cd, (q % 2) == 0);
  endfunction

  function automatic logic [16:0] dead_exp(input int i, input int q, input logic cd);
    return mk(i, q, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cd, (q % 2) == 0);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rdy();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rdy = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #2;
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_dut got=%h exp=%h", obs, 17'd0); end
    n_tests++; if (obs0 !== 17'd0) begin n_fail++; $display("FAIL reset_dut0 got=%h exp=%h", obs0, 17'd0); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_bipolar();
    logic [16:0] e;
    int p;
    do_reset();
    qlen = 8'd3; uni = 1'b0; en = 1'b1;
    tick();
    e = run_exp(0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_start got=%h exp=%h", obs, e); end
    for (int n = 1; n <= 12; n++) begin
      pulse_rdy();
      p = n % 12;
      if (n % 6 == 0) begin
        e = dead_exp(bip_i[p], bip_q[p], n == 12);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_dead_entry rdy%0d got=%h exp=%h", n, obs, e); end
        for (int d = 2; d <= 4; d++) begin
          tick();
          e = dead_exp(bip_i[p], bip_q[p], 1'b0);
          n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_dead%0d rdy%0d got=%h exp=%h", d, n, obs, e); end
        end
        tick();
        e = run_exp(bip_i[p], bip_q[p], 1'b0, 1'b1, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_resume rdy%0d got=%h exp=%h", n, obs, e); end
        repeat (4) tick();
      end else begin
        e = run_exp(bip_i[p], bip_q[p], 1'b0, 1'b1, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_rdy%0d got=%h exp=%h", n, obs, e); end
        tick();
        e = run_exp(bip_i[p], bip_q[p], 1'b0, 1'b0, 1'b0);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bip_hold%0d got=%h exp=%h", n, obs, e); end
        repeat (8) tick();
      end
    end
    en = 1'b0;
  endtask

  task automatic test_unipolar();
    logic [16:0] e;
    int p;
    do_reset();
    qlen = 8'd2; uni = 1'b1; en = 1'b1;
    tick();
    e = run_exp(0, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL uni_start got=%h exp=%h", obs, e); end
    for (int n = 1; n <= 8; n++) begin
      pulse_rdy();
      p = n % 4;
      e = run_exp(uni_i[p], uni_q[p], 1'b1, 1'b1, p == 0);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL uni_rdy%0d got=%h exp=%h", n, obs, e); end
      repeat (3) tick();
    end
    en = 1'b0;
    uni = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    int p;
    do_reset();
    qlen = 8'd1; uni = 1'b0; en = 1'b1;
    tick();
    e = run_exp(0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs0 !== e) begin n_fail++; $display("FAIL b2b_start got=%h exp=%h", obs0, e); end
    rdy = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      p = n % 4;
      e = run_exp(p % 2, p, 1'b0, 1'b1, p == 0);
      n_tests++; if (obs0 !== e) begin n_fail++; $display("FAIL b2b_rdy%0d got=%h exp=%h", n, obs0, e); end
    end
    rdy = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_stop();
    logic [16:0] e;
    int p;
    do_reset();
    qlen = 8'd3; uni = 1'b0; en = 1'b1;
    tick();
    for (int n = 1; n <= 12; n++) begin
      pulse_rdy();
      p = n % 12;
      if (n == 12) e = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (n == 6) e = dead_exp(bip_i[p], bip_q[p], 1'b0);
      else e = run_exp(bip_i[p], bip_q[p], 1'b0, 1'b1, 1'b0);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL stop_rdy%0d got=%h exp=%h", n, obs, e); end
      if (n == 5) en = 1'b0;
      repeat (6) tick();
    end
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL stop_idle got=%h exp=%h", obs, 17'd0); end
  endtask

  task automatic test_qlen_change();
    logic [16:0] e;
    int p;
    do_reset();
    qlen = 8'd3; uni = 1'b0; en = 1'b1;
    tick();
    for (int n = 1; n <= 12; n++) begin
      pulse_rdy();
      p = n % 12;
      if (n % 6 == 0) e = dead_exp(bip_i[p], bip_q[p], n == 12);
      else e = run_exp(bip_i[p], bip_q[p], 1'b0, 1'b1, 1'b0);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL qchg_rdy%0d got=%h exp=%h", n, obs, e); end
      if (n == 2) qlen = 8'd5;
      repeat (6) tick();
    end
    e = run_exp(0, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL qchg_resume got=%h exp=%h", obs, e); end
    for (int n = 0; n < 6; n++) begin
      pulse_rdy();
      e = run_exp(q5_i[n], q5_q[n], 1'b0, 1'b1, 1'b0);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL q5_rdy%0d got=%h exp=%h", n + 1, obs, e); end
      repeat (2) tick();
    end
    en = 1'b0;
  endtask

  task automatic test_ignore();
    logic [16:0] e;
    do_reset();
    qlen = 8'd3; en = 1'b0;
    pulse_rdy();
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL idle_rdy got=%h exp=%h", obs, 17'd0); end
    qlen = 8'd0; en = 1'b1;
    repeat (3) tick();
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL qlen0_idle got=%h exp=%h", obs, 17'd0); end
    qlen = 8'd1;
    tick();
    e = run_exp(0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ign_start got=%h exp=%h", obs, e); end
    pulse_rdy();
    e = run_exp(1, 1, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ign_peak got=%h exp=%h", obs, e); end
    tick();
    pulse_rdy();
    e = dead_exp(0, 2, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ign_dead1 got=%h exp=%h", obs, e); end
    pulse_rdy();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL dead_rdy got=%h exp=%h", obs, e); end
    repeat (2) tick();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ign_dead4 got=%h exp=%h", obs, e); end
    tick();
    e = run_exp(0, 2, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ign_resume got=%h exp=%h", obs, e); end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [16:0] e;
    do_reset();
    qlen = 8'd3; uni = 1'b0; en = 1'b1;
    tick();
    repeat (6) pulse_rdy();
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL rst_dead got=%h exp=%h", obs, 17'd0); end
    rst = 1'b1;
    tick();
    e = run_exp(0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL rst_restart1 got=%h exp=%h", obs, e); end
    pulse_rdy();
    e = run_exp(1, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL rst_run_adv got=%h exp=%h", obs, e); end
    rst = 1'b0;
    #1;
    n_tests++; if (obs !== 17'd0) begin n_fail++; $display("FAIL rst_run got=%h exp=%h", obs, 17'd0); end
    rst = 1'b1;
    tick();
    e = run_exp(0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL rst_restart2 got=%h exp=%h", obs, e); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bipolar();
    test_unipolar();
    test_back_to_back();
    test_stop();
    test_qlen_change();
    test_ignore();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
